// File: rtl/rx_block_lock_pkg.sv
// Shared PCS definitions: 64b/66b sync header codes and block-lock state encoding.
package rx_block_lock_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic {
    BL_TEST      = 1'b0,
    BL_SLIP_WAIT = 1'b1
  } bl_state_e;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b receive block lock: sync-header test windows, gearbox slip requests,
// per-header invalid strobe and a saturating lock-loss counter.
module rx_block_lock
  import rx_block_lock_pkg::*;
#(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 4
) (
  input  logic       clk156,
  input  logic       rstb156,
  input  logic [1:0] rx_hdr,
  input  logic       rx_hdr_vld,
  input  logic       clear_lockloss,
  output logic       blk_lock,
  output logic       slip,
  output logic       sh_invld,
  output logic [7:0] lockloss_cnt
);

  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int IVW = $clog2(SH_INVLD_MAX + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  localparam logic [SHW:0]   SH_LAST  = (SHW + 1)'(SH_CNT_MAX);
  localparam logic [IVW:0]   IV_LAST  = (IVW + 1)'(SH_INVLD_MAX);
  localparam logic [WTW-1:0] WT_LOAD  = WTW'(SLIP_WAIT);

  bl_state_e      state, state_d;
  logic [SHW-1:0] sh_cnt, sh_cnt_d;
  logic [IVW-1:0] invld_cnt, invld_cnt_d;
  logic [WTW-1:0] wait_cnt, wait_cnt_d;
  logic           lock_d, slip_d, invld_d, drop;
  logic [7:0]     lockloss_d;

  logic           bad;
  logic [SHW:0]   n;
  logic [IVW:0]   m;

  assign bad = ~hdr_is_valid(rx_hdr);
  assign n   = {1'b0, sh_cnt} + {{SHW{1'b0}}, 1'b1};
  assign m   = {1'b0, invld_cnt} + {{IVW{1'b0}}, bad};

  always_comb begin
    state_d     = state;
    sh_cnt_d    = sh_cnt;
    invld_cnt_d = invld_cnt;
    wait_cnt_d  = wait_cnt;
    lock_d      = blk_lock;
    slip_d      = 1'b0;
    invld_d     = 1'b0;
    drop        = 1'b0;
    case (state)
      BL_TEST: begin
        if (rx_hdr_vld) begin
          invld_d = bad;
          if (bad && (!blk_lock || m == IV_LAST)) begin
            slip_d      = 1'b1;
            lock_d      = 1'b0;
            drop        = blk_lock;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
            wait_cnt_d  = WT_LOAD;
            state_d     = BL_SLIP_WAIT;
          end else if (n == SH_LAST) begin
            if (m == '0) lock_d = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            // n < SH_CNT_MAX and m < SH_INVLD_MAX here, so truncation is lossless
            sh_cnt_d    = n[SHW-1:0];
            invld_cnt_d = m[IVW-1:0];
          end
        end
      end
      BL_SLIP_WAIT: begin
        wait_cnt_d = wait_cnt - 1'b1;
        if (wait_cnt <= WTW'(1)) begin
          wait_cnt_d = '0;
          state_d    = BL_TEST;
        end
      end
      default: state_d = BL_TEST;
    endcase

    lockloss_d = lockloss_cnt;
    if (clear_lockloss)
      lockloss_d = '0;
    else if (drop && lockloss_cnt != 8'hFF)
      lockloss_d = lockloss_cnt + 8'd1;
  end

  always_ff @(posedge clk156) begin
    if (!rstb156) begin
      state        <= BL_TEST;
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      wait_cnt     <= '0;
      blk_lock     <= 1'b0;
      slip         <= 1'b0;
      sh_invld     <= 1'b0;
      lockloss_cnt <= '0;
    end else begin
      state        <= state_d;
      sh_cnt       <= sh_cnt_d;
      invld_cnt    <= invld_cnt_d;
      wait_cnt     <= wait_cnt_d;
      blk_lock     <= lock_d;
      slip         <= slip_d;
      sh_invld     <= invld_d;
      lockloss_cnt <= lockloss_d;
    end
  end

endmodule

// File: tb/tb_rx_block_lock.sv
// Scoreboarded bench for rx_block_lock: directed scenarios plus random traffic,
// expected outputs from a window/timestamp level model of the lock rules.
module tb_rx_block_lock;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 4;

  logic       clk156 = 1'b0;
  logic       rstb156 = 1'b0;
  logic [1:0] rx_hdr = 2'b00;
  logic       rx_hdr_vld = 1'b0;
  logic       clear_lockloss = 1'b0;
  logic       blk_lock, slip, sh_invld;
  logic [7:0] lockloss_cnt;

  rx_block_lock #(
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX),
    .SLIP_WAIT   (SLIP_WAIT)
  ) dut (
    .clk156        (clk156),
    .rstb156       (rstb156),
    .rx_hdr        (rx_hdr),
    .rx_hdr_vld    (rx_hdr_vld),
    .clear_lockloss(clear_lockloss),
    .blk_lock      (blk_lock),
    .slip          (slip),
    .sh_invld      (sh_invld),
    .lockloss_cnt  (lockloss_cnt)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic       lock;
    logic       slp;
    logic       inv;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Reference model: a window is a list of header verdicts; lock is decided per window.
  bit m_locked = 0;
  int m_win_hdrs = 0;
  int m_win_bad = 0;
  int m_ignore_left = 0;
  int m_lossses = 0;

  task automatic step(input logic [1:0] hdr, input logic vld, input logic clr, input logic rst_n);
    exp_t e;
    bit   is_bad, slp, inv, drop;
    @(posedge clk156);
    #1;
    rx_hdr = hdr; rx_hdr_vld = vld; clear_lockloss = clr; rstb156 = rst_n;
    cycle_no++;
    slp = 0; inv = 0; drop = 0;
    if (!rst_n) begin
      m_locked = 0; m_win_hdrs = 0; m_win_bad = 0; m_ignore_left = 0; m_lossses = 0;
    end else begin
      if (m_ignore_left > 0) begin
        m_ignore_left--;
      end else if (vld) begin
        is_bad = !(hdr == 2'b01 || hdr == 2'b10);
        inv = is_bad;
        m_win_hdrs++;
        if (is_bad) m_win_bad++;
        if (is_bad && (!m_locked || m_win_bad == SH_INVLD_MAX)) begin
          drop = m_locked;
          m_locked = 0;
          slp = 1;
          m_win_hdrs = 0; m_win_bad = 0;
          m_ignore_left = SLIP_WAIT;
        end else if (m_win_hdrs == SH_CNT_MAX) begin
          if (m_win_bad == 0) m_locked = 1;
          m_win_hdrs = 0; m_win_bad = 0;
        end
      end
      if (clr) m_lossses = 0;
      else if (drop) m_lossses = (m_lossses >= 255) ? 255 : m_lossses + 1;
    end
    e.lock = m_locked; e.slp = slp; e.inv = inv; e.cnt = 8'(m_lossses); e.cyc = cycle_no;
    exp_q.push_back(e);
  endtask

  task automatic hdr_cyc(input logic [1:0] hdr);
    step(hdr, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [1:0] rnd_good();
    return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] rnd_bad();
    return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic acquire();
    for (int i = 0; i < SH_CNT_MAX; i++) hdr_cyc(rnd_good());
  endtask

  // Monitor: the entry pushed in cycle k describes outputs after the next edge,
  // so it is compared once a newer entry exists.
  always @(negedge clk156) begin
    exp_t e;
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      checks++;
      if (blk_lock !== e.lock || slip !== e.slp || sh_invld !== e.inv || lockloss_cnt !== e.cnt) begin
        errors++;
        $display("FAIL outputs stim_cycle=%0d got lock=%b slip=%b inv=%b cnt=%0d exp lock=%b slip=%b inv=%b cnt=%0d",
                 e.cyc, blk_lock, slip, sh_invld, lockloss_cnt, e.lock, e.slp, e.inv, e.cnt);
      end
    end
  end

  initial begin
    bit bad_pos[SH_CNT_MAX];
    int gap;

    // reset state
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, 1'b0);

    // acquisition, alternating 01/10
    for (int i = 0; i < SH_CNT_MAX; i++) hdr_cyc((i % 2) ? 2'b10 : 2'b01);
    idle(2);

    // locked tolerance: 15 invalid headers scattered over one window
    for (int i = 0; i < SH_CNT_MAX; i++) bad_pos[i] = 0;
    for (int k = 0; k < SH_INVLD_MAX - 1; k++) bad_pos[k * 4 + $urandom_range(0, 3)] = 1;
    for (int i = 0; i < SH_CNT_MAX; i++) hdr_cyc(bad_pos[i] ? rnd_bad() : rnd_good());

    // loss of lock: 16th invalid header at index 40
    for (int i = 0; i <= 40; i++)
      hdr_cyc((i == 40 || (i < 30 && i % 2 == 0)) ? rnd_bad() : rnd_good());
    for (int i = 0; i < SLIP_WAIT; i++) hdr_cyc(2'b11);

    // unlocked slip on the 11th header, ignored headers, re-lock
    for (int i = 0; i < 10; i++) hdr_cyc(2'b10);
    hdr_cyc(2'b00);
    for (int i = 0; i < SLIP_WAIT; i++) hdr_cyc(2'b11);
    acquire();
    idle(1);

    // lock-loss counter saturation (257 losses)
    for (int r = 0; r < 257; r++) begin
      acquire();
      for (int i = 0; i < SH_INVLD_MAX; i++) hdr_cyc(rnd_bad());
      idle(SLIP_WAIT);
    end
    // clear coinciding with a further loss
    acquire();
    for (int i = 0; i < SH_INVLD_MAX - 1; i++) hdr_cyc(rnd_bad());
    step(2'b00, 1'b1, 1'b1, 1'b1);
    idle(SLIP_WAIT);

    // reset during SLIP_WAIT, then header evaluated right after release
    hdr_cyc(2'b00);
    hdr_cyc(2'b11);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    hdr_cyc(2'b00);
    idle(SLIP_WAIT);

    // acquisition with 1..5 cycle stall gaps
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      hdr_cyc(rnd_good());
      gap = $urandom_range(0, 3) == 0 ? $urandom_range(1, 5) : 0;
      idle(gap);
    end
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) < 4) ? rnd_bad() : rnd_good(),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 999) != 0);

    idle(2);
    repeat (3) @(negedge clk156);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive-side 64b/66b block-lock state machine, per IEEE 802.3 Clause 49. It sits between the gearbox/aligner and the descrambler. It examines the 2-bit sync header of each received 66-bit block and produces `blk_lock`, which gates the descrambler and 66b decoder. It also emits a `slip` request that shifts the gearbox alignment by one bit. A per-header invalid strobe is exported for the BER monitor that generates `hi_ber`.

## Interface
- `SH_CNT_MAX`, default 64: headers per test window.
- `SH_INVLD_MAX`, default 16: invalid headers within a window that force loss of lock.
- `SLIP_WAIT`, default 4: cycles (≥1) that headers are ignored after a slip, while the gearbox realigns.
- `clk156`  in  1  156.25 MHz PCS clock; the only clock.
- `rstb156`  in  1  reset, synchronous, active-low.
- `rx_hdr`  in  2  sync header of the current block (bits [1:0] of the 66-bit word).
- `rx_hdr_vld`  in  1  `rx_hdr` carries a new header this cycle.
- `clear_lockloss`  in  1  synchronous clear of `lockloss_cnt`.
- `blk_lock`  out  1  block lock achieved (registered).
- `slip`  out  1  one-cycle request to the gearbox to slip by one bit.
- `sh_invld`  out  1  one-cycle pulse per evaluated invalid header.
- `lockloss_cnt`  out  8  saturating count of `blk_lock` 1→0 transitions.

## Operation
- A header is valid if it is 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid.
- State: `TEST` or `SLIP_WAIT`.
  - Counters: `sh_cnt` (0..`SH_CNT_MAX`) and `invld_cnt` (0..`SH_INVLD_MAX`).
  - `wait_cnt` counts down `SLIP_WAIT`.
- In `TEST`, headers are evaluated only when `rx_hdr_vld`=1. Let n = `sh_cnt`+1 and m = `invld_cnt` + (header invalid). Checks are applied in this priority order:
  1. Slip condition: header invalid and (`blk_lock`=0 or m = `SH_INVLD_MAX`).
     - Set `slip` and clear `blk_lock`.
     - Clear both counters.
     - Load `wait_cnt` with `SLIP_WAIT` and go to `SLIP_WAIT`.
  2. Window end: n = `SH_CNT_MAX`.
     - If m = 0, set `blk_lock`=1; otherwise leave `blk_lock` unchanged.
     - Clear both counters.
  3. Otherwise: `sh_cnt` ← n, `invld_cnt` ← m.
- `sh_invld` pulses for every invalid header evaluated in `TEST`, including the one that causes a slip.
- In `SLIP_WAIT`:
  - Headers are ignored; no `sh_invld` pulses.
  - `wait_cnt` decrements each cycle, whether or not `rx_hdr_vld` is high.
  - When `wait_cnt` reaches 0, go to `TEST`.
- Lock-loss counter:
  - `lockloss_cnt` increments whenever `blk_lock` goes 1→0, saturating at 255.
  - If `clear_lockloss` coincides with an increment, clear wins and the result is 0.
- Reset values: `blk_lock`=0, `slip`=0, `sh_invld`=0, `lockloss_cnt`=0. State `TEST`, all counters 0.
- Reset has priority over every other event, including reset asserted during `SLIP_WAIT`.

## Timing
- All outputs are registered. Latency is 1 cycle from the edge that evaluates a header to the output change.
- Lock acquisition from reset with all-valid headers: `blk_lock` rises the cycle after the `SH_CNT_MAX`-th valid header is sampled.
- Slip and lock drop are simultaneous: `slip` is high for exactly cycle T; `blk_lock` drops in cycle T.
- Headers presented in cycles T .. T+`SLIP_WAIT`-1 are ignored. The first header evaluated is in cycle T+`SLIP_WAIT`.
- `rx_hdr_vld` may be low for arbitrary gaps (gearbox stall cycles). Counters hold during gaps.
- Back-to-back valid headers on every cycle are supported; the block has no throughput limit.

## Structure
- The shared PCS package holds:
  - `SYNC_DATA` = 2'b01 and `SYNC_CTRL` = 2'b10, shared with the 66b decoder and the BER monitor.
  - The state enum: `BL_TEST`, `BL_SLIP_WAIT`.
- Single flat module, no sub-modules. Counter widths are derived with `$clog2` of the parameters.

## Test plan
- **Acquisition:** reset, then 64 consecutive valid headers alternating 01/10 → `blk_lock`=0 through the 64th header, 1 on the following cycle; `slip` and `sh_invld` never assert.
- **Unlocked slip:** before lock, header 10 valid, then header 00 as the 11th → `sh_invld` and `slip` pulse once in the next cycle; the next 4 headers (set to 11) are ignored with no further `sh_invld`; the window restarts and 64 valid headers re-achieve lock.
- **Locked tolerance:** with lock held, a 64-header window containing 15 invalid headers → `blk_lock` stays 1, 15 `sh_invld` pulses, no slip.
- **Loss of lock:** with lock held, a window where the 16th invalid header arrives at index 40 → `blk_lock`=0 and `slip`=1 in the same cycle, `lockloss_cnt` 0→1.
- **Counter saturation and clear:** 256 forced lock losses → `lockloss_cnt`=255 and holds there; assert `clear_lockloss` in the same cycle as a further loss → `lockloss_cnt`=0.
- **Reset and gaps:** assert `rstb156`=0 during `SLIP_WAIT` → next cycle all outputs 0 and headers are evaluated immediately after release. Separately, insert `rx_hdr_vld`=0 gaps of 1–5 cycles during acquisition → lock is still achieved after exactly 64 valid headers.
